// File: rtl/pixel_readout_sequencer_if.sv
// ---------------------------------------------------------------------------
// pixel_readout_sequencer_if
// Pixel stream toward the frame buffer: one tagged ADC sample per beat.
//   valid  : sample available (sequencer -> sink)
//   ready  : sink accepts the sample this cycle (sink -> sequencer)
//   data   : ADC sample
//   row    : pixel row of the sample
//   col    : pixel column of the sample
//   sof    : first stored sample of the frame
//   eol    : sample sits in the last ROI column
//   eof    : sample is the last ROI pixel (last row and last column)
// Modports: master = sequencer side, slave = frame buffer side.
// ---------------------------------------------------------------------------
interface pixel_readout_sequencer_if #(
  parameter int ADC_W = 14
);
  logic             valid;
  logic             ready;
  logic [ADC_W-1:0] data;
  logic [11:0]      row;
  logic [11:0]      col;
  logic             sof;
  logic             eol;
  logic             eof;

  modport master (
    output valid, data, row, col, sof, eol, eof,
    input  ready
  );

  modport slave (
    input  valid, data, row, col, sof, eol, eof,
    output ready
  );
endinterface

// File: rtl/pixel_readout_sequencer.sv
// ---------------------------------------------------------------------------
// pixel_readout_sequencer
// Receive-side partner of the timing generator. Fires one ADC conversion per
// pixel trigger, tags each returned sample with its row/col and frame markers,
// buffers the tagged samples in a small FIFO and drains them over a
// valid/ready pixel stream.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_frame_busy          : high for the duration of a frame
//   i_frame_complete      : 1-cycle pulse at frame end
//   i_adc_start_trigger   : 1-cycle pulse per pixel
//   i_row_addr/i_col_addr : pixel address, valid with the trigger
//   i_row_end/i_col_end   : last ROI row / column
//   o_adc_conv            : 1-cycle conversion start to the ADC
//   i_adc_valid/i_adc_data: ADC result strobe and value
//   i_err_clr             : clears the sticky error flags
//   o_ovf_err             : sticky, FIFO overflow or trigger during conversion
//   o_timeout_err         : sticky, ADC did not answer in time
//   pix                   : pixel stream (master side)
// ---------------------------------------------------------------------------
module pixel_readout_sequencer #(
  parameter int ADC_W        = 14,
  parameter int FIFO_DEPTH   = 8,
  parameter int CONV_TIMEOUT = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_frame_busy,
  input  logic                            i_frame_complete,
  input  logic                            i_adc_start_trigger,
  input  logic [11:0]                     i_row_addr,
  input  logic [11:0]                     i_col_addr,
  input  logic [11:0]                     i_row_end,
  input  logic [11:0]                     i_col_end,
  output logic                            o_adc_conv,
  input  logic                            i_adc_valid,
  input  logic [ADC_W-1:0]                i_adc_data,
  input  logic                            i_err_clr,
  output logic                            o_ovf_err,
  output logic                            o_timeout_err,
  pixel_readout_sequencer_if.master       pix
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CONV_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CONV
  } state_t;

  typedef struct packed {
    logic [ADC_W-1:0] data;
    logic [11:0]      row;
    logic [11:0]      col;
    logic             sof;
    logic             eol;
    logic             eof;
  } entry_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             r_busyPrev;
  logic             r_sofPending;
  logic             r_endPending;
  logic [CW-1:0]    r_cnt;
  logic [11:0]      r_row;
  logic [11:0]      r_col;
  logic             r_adcConv;
  logic             r_ovfErr;
  logic             r_timeoutErr;
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  entry_t           r_mem [FIFO_DEPTH];

  logic             w_arm;
  logic             w_startConv;
  logic             w_sampleIn;
  logic             w_timeout;
  logic             w_trigDrop;
  logic             w_empty;
  logic             w_full;
  logic             w_read;
  logic             w_write;
  logic             w_wrDrop;
  logic             w_ovfEvent;
  entry_t           w_entry;
  entry_t           w_head;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state and control strobes. The end-of-frame check in ARMED takes
  // precedence over a trigger, so a frame that is over never starts a new
  // conversion. In CONV a returning sample beats the timeout in the same cycle.
  always_comb begin
    w_nextState = r_state;
    w_arm       = 1'b0;
    w_startConv = 1'b0;
    w_sampleIn  = 1'b0;
    w_timeout   = 1'b0;
    w_trigDrop  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_frame_busy && !r_busyPrev) begin
          w_nextState = ARMED;
          w_arm       = 1'b1;
        end
      end
      ARMED: begin
        if (r_endPending || !i_frame_busy) begin
          w_nextState = IDLE;
        end else if (i_adc_start_trigger) begin
          w_nextState = CONV;
          w_startConv = 1'b1;
        end
      end
      CONV: begin
        w_trigDrop = i_adc_start_trigger;
        if (i_adc_valid) begin
          w_sampleIn  = 1'b1;
          w_nextState = ARMED;
        end else if (r_cnt == CW'(CONV_TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_nextState = ARMED;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // FIFO status. Pointers carry one extra bit so full and empty differ only
  // in that MSB. A read in the same cycle frees the slot for a write on full.
  assign w_empty    = (r_wrPtr == r_rdPtr);
  assign w_full     = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                      (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_read     = !w_empty && pix.ready;
  assign w_write    = w_sampleIn && (!w_full || w_read);
  assign w_wrDrop   = w_sampleIn && w_full && !w_read;
  assign w_ovfEvent = w_wrDrop || w_trigDrop;

  always_comb begin
    w_entry      = '0;
    w_entry.data = i_adc_data;
    w_entry.row  = r_row;
    w_entry.col  = r_col;
    w_entry.sof  = r_sofPending;
    w_entry.eol  = (r_col == i_col_end);
    w_entry.eof  = (r_row == i_row_end) && (r_col == i_col_end);
  end

  // Control and status registers. sof stays pending until a sample is
  // actually stored, so a timed-out or dropped first pixel hands the marker
  // to the next stored sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busyPrev   <= 1'b0;
      r_sofPending <= 1'b1;
      r_endPending <= 1'b0;
      r_cnt        <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_adcConv    <= 1'b0;
      r_ovfErr     <= 1'b0;
      r_timeoutErr <= 1'b0;
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
    end else begin
      r_busyPrev <= i_frame_busy;
      r_adcConv  <= w_startConv;

      if (w_arm)               r_sofPending <= 1'b1;
      else if (w_write)        r_sofPending <= 1'b0;

      if (w_arm)               r_endPending <= 1'b0;
      else if (i_frame_complete && (r_state != IDLE))
                               r_endPending <= 1'b1;

      if (w_startConv) begin
        r_row <= i_row_addr;
        r_col <= i_col_addr;
        r_cnt <= '0;
      end else if (r_state == CONV) begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_ovfEvent)          r_ovfErr <= 1'b1;
      else if (i_err_clr)      r_ovfErr <= 1'b0;

      if (w_timeout)           r_timeoutErr <= 1'b1;
      else if (i_err_clr)      r_timeoutErr <= 1'b0;

      if (w_write)             r_wrPtr <= r_wrPtr + PW'(1);
      if (w_read)              r_rdPtr <= r_rdPtr + PW'(1);
    end
  end

  // Sample storage; contents are meaningless while the pointers say empty.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wrPtr[AW-1:0]] <= w_entry;
  end

  assign w_head = r_mem[r_rdPtr[AW-1:0]];

  // Stream outputs are forced to zero while empty so reset shows all zeros.
  assign pix.valid = !w_empty;
  assign pix.data  = w_empty ? '0    : w_head.data;
  assign pix.row   = w_empty ? '0    : w_head.row;
  assign pix.col   = w_empty ? '0    : w_head.col;
  assign pix.sof   = w_empty ? 1'b0  : w_head.sof;
  assign pix.eol   = w_empty ? 1'b0  : w_head.eol;
  assign pix.eof   = w_empty ? 1'b0  : w_head.eof;

  assign o_adc_conv    = r_adcConv;
  assign o_ovf_err     = r_ovfErr;
  assign o_timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_pixel_readout_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pixel_readout_sequencer
// Plays the timing generator and the ADC toward pixel_readout_sequencer.
// Every answered pixel that should land in the FIFO is pushed onto an
// expected queue; an independent monitor pops it when the stream transfers.
// ---------------------------------------------------------------------------
module tb_pixel_readout_sequencer;

  localparam int ADC_W        = 14;
  localparam int FIFO_DEPTH   = 8;
  localparam int CONV_TIMEOUT = 64;

  typedef struct {
    logic [ADC_W-1:0] data;
    logic [11:0]      row;
    logic [11:0]      col;
    logic             sof;
    logic             eol;
    logic             eof;
  } pix_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             frameBusy;
  logic             frameComplete;
  logic             trigger;
  logic [11:0]      rowAddr;
  logic [11:0]      colAddr;
  logic [11:0]      rowEnd;
  logic [11:0]      colEnd;
  logic             adcConv;
  logic             adcValid;
  logic [ADC_W-1:0] adcData;
  logic             errClr;
  logic             ovfErr;
  logic             timeoutErr;

  pixel_readout_sequencer_if #(.ADC_W(ADC_W)) pixIf ();

  pixel_readout_sequencer #(
    .ADC_W(ADC_W), .FIFO_DEPTH(FIFO_DEPTH), .CONV_TIMEOUT(CONV_TIMEOUT)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_frame_busy        (frameBusy),
    .i_frame_complete    (frameComplete),
    .i_adc_start_trigger (trigger),
    .i_row_addr          (rowAddr),
    .i_col_addr          (colAddr),
    .i_row_end           (rowEnd),
    .i_col_end           (colEnd),
    .o_adc_conv          (adcConv),
    .i_adc_valid         (adcValid),
    .i_adc_data          (adcData),
    .i_err_clr           (errClr),
    .o_ovf_err           (ovfErr),
    .o_timeout_err       (timeoutErr),
    .pix                 (pixIf)
  );

  pix_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   readyMode = 1;
  int   convCount = 0;
  int   popCount = 0;
  bit   frameSofDue = 1'b0;
  bit   expTimeout = 1'b0;

  // Free-running clock.
  always #5 clk = ~clk;

  // Stream sink: ready held low, held high or randomized per cycle.
  initial begin
    pixIf.ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       pixIf.ready = 1'b0;
        1:       pixIf.ready = 1'b1;
        default: pixIf.ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Hard stop in case something wedges the stimulus.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before the end of stimulus");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: counts conversion pulses, checks stall stability and pops the
  // expected queue on every accepted beat.
  logic [ADC_W+26:0] snap;
  bit                stalledPrev = 1'b0;
  always @(negedge clk) begin
    pix_t             e;
    logic [ADC_W+26:0] cur;
    if (!rst_n) begin
      stalledPrev = 1'b0;
    end else begin
      if (adcConv) convCount++;
      cur = {pixIf.data, pixIf.row, pixIf.col, pixIf.sof, pixIf.eol, pixIf.eof};
      if (pixIf.valid && stalledPrev)
        checkOutput("stall_stable", 64'(cur), 64'(snap));
      if (pixIf.valid && pixIf.ready) begin
        popCount++;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pixel actual row=%0d col=%0d expected none",
                   pixIf.row, pixIf.col);
        end else begin
          e = expQ.pop_front();
          checkOutput("pix_data",  64'(pixIf.data), 64'(e.data));
          checkOutput("pix_coord", 64'({pixIf.row, pixIf.col}), 64'({e.row, e.col}));
          checkOutput("pix_flags", 64'({pixIf.sof, pixIf.eol, pixIf.eof}),
                      64'({e.sof, e.eol, e.eof}));
        end
      end
      stalledPrev = pixIf.valid && !pixIf.ready;
      snap        = cur;
    end
  end

  task automatic startFrame(input int re, input int ce);
    rowEnd      = 12'(re);
    colEnd      = 12'(ce);
    frameBusy   = 1'b1;
    frameSofDue = 1'b1;
    tick();
  endtask

  task automatic endFrame();
    frameComplete = 1'b1;
    tick();
    frameComplete = 1'b0;
    frameBusy     = 1'b0;
    tick();
    tick();
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((expQ.size() != 0 || pixIf.valid) && n < 400) begin
      tick();
      n++;
    end
    checkOutput("drain_left", 64'(expQ.size()), 64'd0);
  endtask

  task automatic clearErrors();
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    expTimeout = 1'b0;
    checkOutput("err_clr_ovf", 64'(ovfErr), 64'd0);
    checkOutput("err_clr_timeout", 64'(timeoutErr), 64'd0);
  endtask

  // One pixel: trigger, expect a single conv pulse the next cycle, then
  // either answer after `latency` cycles or let the conversion time out.
  task automatic applyStimulus(input int row, input int col, input bit answer,
                               input int latency, input bit expectStore,
                               input bit completeInConv);
    pix_t e;
    trigger = 1'b1;
    rowAddr = 12'(row);
    colAddr = 12'(col);
    tick();
    trigger = 1'b0;
    checkOutput("adc_conv_pulse", 64'(adcConv), 64'd1);
    if (completeInConv) frameComplete = 1'b1;
    if (answer) begin
      tick();
      frameComplete = 1'b0;
      checkOutput("adc_conv_single", 64'(adcConv), 64'd0);
      repeat (latency - 1) tick();
      adcValid = 1'b1;
      adcData  = ADC_W'($urandom);
      if (expectStore) begin
        e.data = adcData;
        e.row  = 12'(row);
        e.col  = 12'(col);
        e.sof  = frameSofDue;
        e.eol  = (col == int'(colEnd));
        e.eof  = (row == int'(rowEnd)) && (col == int'(colEnd));
        expQ.push_back(e);
        frameSofDue = 1'b0;
      end
      tick();
      adcValid = 1'b0;
    end else begin
      tick();
      frameComplete = 1'b0;
      repeat (CONV_TIMEOUT - 2) tick();
      checkOutput("timeout_early", 64'(timeoutErr), 64'(expTimeout));
      tick();
      checkOutput("timeout_at_limit", 64'(timeoutErr), 64'd1);
      expTimeout = 1'b1;
    end
  endtask

  initial begin
    int startPops;
    rst_n = 1'b0;
    frameBusy = 0; frameComplete = 0; trigger = 0; rowAddr = 0; colAddr = 0;
    rowEnd = 0; colEnd = 0; adcValid = 0; adcData = 0; errClr = 0;
    repeat (3) tick();
    checkOutput("reset_pix_valid", 64'(pixIf.valid), 64'd0);
    checkOutput("reset_adc_conv", 64'(adcConv), 64'd0);
    checkOutput("reset_ovf", 64'(ovfErr), 64'd0);
    checkOutput("reset_timeout", 64'(timeoutErr), 64'd0);
    rst_n = 1'b1;
    tick();

    // 2x2 ROI, ADC latency 3, sink always ready.
    $display("[TB] 2x2 ROI frame");
    readyMode = 1;
    startFrame(1, 1);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        applyStimulus(r, c, 1'b1, 3, 1'b1, 1'b0);
    endFrame();
    waitDrain();
    checkOutput("roi_ovf", 64'(ovfErr), 64'd0);
    checkOutput("roi_timeout", 64'(timeoutErr), 64'd0);

    // Sink stalled: 10 answered pixels, only the first FIFO_DEPTH survive.
    $display("[TB] FIFO overflow while stalled");
    readyMode = 0;
    tick();
    startFrame(3, 3);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i / 4, i % 4, 1'b1, 2, (i < FIFO_DEPTH), 1'b0);
      if (i == FIFO_DEPTH - 1) checkOutput("ovf_before_full", 64'(ovfErr), 64'd0);
    end
    checkOutput("ovf_after_full", 64'(ovfErr), 64'd1);
    endFrame();
    repeat (3) tick();
    startPops = popCount;
    readyMode = 1;
    waitDrain();
    checkOutput("drain_count", 64'(popCount - startPops), 64'(FIFO_DEPTH));
    clearErrors();

    // ADC silent on the first pixel: timeout, no write, sof moves on.
    $display("[TB] conversion timeout");
    startFrame(1, 1);
    applyStimulus(0, 0, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(0, 1, 1'b1, 3, 1'b1, 1'b0);
    applyStimulus(1, 0, 1'b1, 4, 1'b1, 1'b0);
    applyStimulus(1, 1, 1'b1, 1, 1'b1, 1'b0);
    endFrame();
    waitDrain();
    checkOutput("timeout_sticky", 64'(timeoutErr), 64'd1);
    checkOutput("timeout_no_ovf", 64'(ovfErr), 64'd0);
    clearErrors();

    // Second trigger one cycle after the first, ADC latency 5.
    $display("[TB] trigger during conversion");
    startFrame(1, 1);
    convCount = 0;
    begin
      pix_t e;
      trigger = 1'b1; rowAddr = 0; colAddr = 0;
      tick();
      checkOutput("dbl_conv_pulse", 64'(adcConv), 64'd1);
      colAddr = 1;
      tick();
      trigger = 1'b0;
      repeat (4) tick();
      adcValid = 1'b1;
      adcData  = ADC_W'($urandom);
      e.data = adcData; e.row = 0; e.col = 0; e.sof = 1'b1; e.eol = 1'b0; e.eof = 1'b0;
      expQ.push_back(e);
      frameSofDue = 1'b0;
      tick();
      adcValid = 1'b0;
      tick();
    end
    checkOutput("dbl_conv_count", 64'(convCount), 64'd1);
    checkOutput("dbl_ovf", 64'(ovfErr), 64'd1);
    endFrame();
    waitDrain();
    clearErrors();

    // frame_complete during a conversion: sample kept, then IDLE.
    $display("[TB] frame_complete during conversion");
    startFrame(1, 1);
    applyStimulus(0, 0, 1'b1, 2, 1'b1, 1'b0);
    applyStimulus(0, 1, 1'b1, 3, 1'b1, 1'b1);
    tick();
    trigger = 1'b1; rowAddr = 1; colAddr = 0;
    tick();
    trigger = 1'b0;
    checkOutput("idle_trigger_ignored", 64'(adcConv), 64'd0);
    frameBusy = 1'b0;
    tick();
    waitDrain();
    checkOutput("idle_trigger_no_ovf", 64'(ovfErr), 64'd0);
    startFrame(1, 1);
    applyStimulus(0, 0, 1'b1, 2, 1'b1, 1'b0);
    applyStimulus(0, 1, 1'b1, 2, 1'b1, 1'b0);
    endFrame();
    waitDrain();

    // Async reset with samples queued and a sticky flag set.
    $display("[TB] reset mid-frame");
    readyMode = 0;
    tick();
    startFrame(1, 1);
    applyStimulus(0, 0, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(0, 1, 1'b1, 2, 1'b0, 1'b0);
    applyStimulus(1, 0, 1'b1, 2, 1'b0, 1'b0);
    applyStimulus(1, 1, 1'b1, 2, 1'b0, 1'b0);
    checkOutput("pre_reset_valid", 64'(pixIf.valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", 64'(pixIf.valid), 64'd0);
    checkOutput("async_reset_timeout", 64'(timeoutErr), 64'd0);
    checkOutput("async_reset_ovf", 64'(ovfErr), 64'd0);
    frameBusy = 1'b0;
    expTimeout = 1'b0;
    tick();
    rst_n = 1'b1;
    startPops = popCount;
    readyMode = 1;
    repeat (10) tick();
    checkOutput("post_reset_valid", 64'(pixIf.valid), 64'd0);
    checkOutput("post_reset_pops", 64'(popCount - startPops), 64'd0);

    // Randomized frames: random ROI, latency, gaps, missed answers, sink stalls.
    $display("[TB] randomized frames");
    readyMode = 2;
    for (int f = 0; f < 8; f++) begin
      int re = $urandom_range(0, 1);
      int ce = $urandom_range(0, 3);
      startFrame(re, ce);
      for (int r = 0; r <= re; r++)
        for (int c = 0; c <= ce; c++) begin
          repeat ($urandom_range(0, 2)) tick();
          applyStimulus(r, c, ($urandom_range(0, 7) != 0), $urandom_range(1, 6),
                        1'b1, 1'b0);
        end
      endFrame();
      waitDrain();
      checkOutput("rnd_timeout_flag", 64'(timeoutErr), 64'(expTimeout));
      checkOutput("rnd_ovf_flag", 64'(ovfErr), 64'd0);
      clearErrors();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
